transpose_buffer: RTL and testbench
===================================

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port en, input, 1, global enable; en=0 freezes all state.
REQ-004 SHALL have ports I0..I7, input, 32 each, one DCT output row of IEEE-754 single-precision words, carried as raw bits.
REQ-005 SHALL have port in_valid, input, 1, row present on I0..I7.
REQ-006 SHALL have port in_ready, output, 1, buffer can accept a row.
REQ-007 SHALL have ports C0..C7, output, 32 each, one transposed column; Ck = element k of column j.
REQ-008 SHALL have port out_valid, output, 1, a column is present on C0..C7.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the column.
REQ-010 SHALL have port out_last, output, 1, high with out_valid on column 7 of a block.

Function
REQ-011 SHALL accept a row on a rising edge only when en && in_valid && in_ready, storing I0..I7 as row wr_row (3-bit, 0..7).
REQ-012 SHALL increment wr_row on each accepted row; the 7->0 wrap SHALL mark the write bank full.
REQ-013 SHALL assert out_valid the cycle after the 8th row of a block is accepted, giving a one-cycle row-to-column latency.
REQ-014 SHALL drive Ck = stored row k, element rd_col, while out_valid=1.
REQ-015 SHALL drive C0..C7 = 0 while out_valid=0.
REQ-016 SHALL advance rd_col (3-bit) only when en && out_valid && out_ready.
REQ-017 SHALL free the read bank on the transfer with rd_col=7; out_last=1 only on that column.
REQ-018 SHALL force in_ready=0 and out_valid=0 while en=0, and SHALL leave all counters and storage unchanged.
REQ-019 SHALL hold C0..C7 and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL pass all 32-bit words bit-exact, with no arithmetic and no float interpretation.
REQ-021 SHALL, when a read-bank free and a write-bank full occur in the same cycle, process both events: banks swap roles with no lost or duplicated column.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, clear wr_row, rd_col and bank-full flags, and select bank 0 for write.
REQ-023 SHALL hold out_valid=0, out_last=0 and C0..C7=0 during reset; in_ready=1 in the first cycle after reset with en=1.
REQ-024 SHALL discard partial rows and full banks on reset mid-block; storage contents need not be cleared.

Configuration
REQ-025 SHALL, with TRANSPOSE_PINGPONG_EN defined, implement two banks, allowing a new block to be written while the previous block is read.
REQ-026 SHALL, with TRANSPOSE_PINGPONG_EN defined, set in_ready=0 only when both banks are full.
REQ-027 SHALL, without TRANSPOSE_PINGPONG_EN, implement one bank and set in_ready=0 from the cycle the bank becomes full until the cycle after the out_last transfer.

Structure
REQ-028 SHALL take WORD_W=32, BLK_N=8 and a row typedef (8 x WORD_W) from shared package jpeg_pkg.
REQ-029 SHALL implement storage as sub-module transpose_bank: 8x8 words, row write port, column read port, instantiated once or twice per REQ-025/027.

Verification
REQ-030 SHALL cover basic transpose: rows r=0..7 with Ic=32'h000000{r,c} (e.g. row 2, col 5 = 32'h25), out_ready=1 -> columns j=0..7 with Ck=32'h{k,j}, out_valid 1 cycle after row 7, out_last on column 7.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles on column 3 -> C0..C7 held at 32'h03,32'h13,..,32'h73; no column skipped.
REQ-032 SHALL cover pingpong streaming (macro defined): two blocks back-to-back with in_valid=1 -> in_ready stays 1 throughout the second block; columns of block 1 then block 2 in order. Without the macro: in_ready=0 for 8 cycles while block 1 drains.
REQ-033 SHALL cover enable freeze: en=0 for 4 cycles mid-block after row 4 -> in_ready=out_valid=0; after resume, row 5 is accepted as row 5 and the output is identical to REQ-030.
REQ-034 SHALL cover reset mid-block: reset after 3 rows, then a full 8-row block of float 1.0 (32'h3F800000) -> all 8 columns are 32'h3F800000; no stale data.
REQ-035 SHALL cover the simultaneous swap: the block-2 row 7 write coincides with the block-1 column 7 read -> block 2 out_valid the next cycle with no gap and no duplicate.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG block datapath: word width, block size and row type.
package jpeg_pkg;
  localparam int WORD_W = 32;
  localparam int BLK_N  = 8;

  // Element 0 sits in the low word so that {I7, ..., I0} packs directly.
  typedef logic [BLK_N-1:0][WORD_W-1:0] row_t;
endpackage

// File: rtl/transpose_bank.sv
// One 8x8 block of words: a full row is written per cycle, a full column is read combinationally.
module transpose_bank
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] wr_row,
  input  row_t       wr_data,
  input  logic [2:0] rd_col,
  output row_t       rd_data
);

  // Pure data storage with no reset; the buffer's control state decides what is valid.
  row_t mem [BLK_N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < BLK_N; k++) begin
      rd_data[k] = mem[k][rd_col];
    end
  end

endmodule

// File: rtl/transpose_buffer.sv
// Row-in / column-out transpose buffer for 8x8 blocks of raw 32-bit words.
// Define TRANSPOSE_PINGPONG_EN for two banks, so a new block is written while the previous one drains.
module transpose_buffer
  import jpeg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [31:0] I4,
  input  logic [31:0] I5,
  input  logic [31:0] I6,
  input  logic [31:0] I7,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] C0,
  output logic [31:0] C1,
  output logic [31:0] C2,
  output logic [31:0] C3,
  output logic [31:0] C4,
  output logic [31:0] C5,
  output logic [31:0] C6,
  output logic [31:0] C7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

`ifdef TRANSPOSE_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  logic [2:0] wr_row;
  logic [2:0] rd_col;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_bank;
  logic       rd_bank;
  logic       wr_fire;
  logic       rd_fire;
  row_t       wr_data;
  row_t       rd_data0;
  row_t       col;
  row_t       col_out;

  assign wr_data = {I7, I6, I5, I4, I3, I2, I1, I0};

  // A bank is writable until it holds a complete, unread block.
  assign in_ready  = en && !reset && !full[wr_bank];
  assign out_valid = en && !reset && full[rd_bank];
  assign out_last  = out_valid && (rd_col == 3'd7);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  transpose_bank u_bank0 (
    .clk     (clk),
    .we      (wr_fire && !wr_bank),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_col  (rd_col),
    .rd_data (rd_data0)
  );

`ifdef TRANSPOSE_PINGPONG_EN
  row_t rd_data1;

  transpose_bank u_bank1 (
    .clk     (clk),
    .we      (wr_fire && wr_bank),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_col  (rd_col),
    .rd_data (rd_data1)
  );

  assign col = rd_bank ? rd_data1 : rd_data0;
`else
  assign col = rd_data0;
`endif

  assign col_out = out_valid ? col : '0;
  assign C0 = col_out[0];
  assign C1 = col_out[1];
  assign C2 = col_out[2];
  assign C3 = col_out[3];
  assign C4 = col_out[4];
  assign C5 = col_out[5];
  assign C6 = col_out[6];
  assign C7 = col_out[7];

  // Fill and drain touch different banks, so both updates apply when they coincide.
  always_comb begin
    full_nxt = full;
    if (wr_fire && (wr_row == 3'd7)) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_fire && (rd_col == 3'd7)) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row  <= '0;
      rd_col  <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) begin
          wr_bank <= wr_bank ^ PINGPONG;
        end
      end
      if (rd_fire) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) begin
          rd_bank <= rd_bank ^ PINGPONG;
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer against a queue-of-blocks reference model.
// Honours TRANSPOSE_PINGPONG_EN to pick one- or two-block buffering in the model.
module tb_transpose_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] iv [8];
  logic        in_ready;
  logic        out_valid;
  logic        out_last;
  logic [31:0] cv [8];

  always #5 clk = ~clk;

  transpose_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .I0        (iv[0]),
    .I1        (iv[1]),
    .I2        (iv[2]),
    .I3        (iv[3]),
    .I4        (iv[4]),
    .I5        (iv[5]),
    .I6        (iv[6]),
    .I7        (iv[7]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C0        (cv[0]),
    .C1        (cv[1]),
    .C2        (cv[2]),
    .C3        (cv[3]),
    .C4        (cv[4]),
    .C5        (cv[5]),
    .C6        (cv[6]),
    .C7        (cv[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

`ifdef TRANSPOSE_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef logic [31:0] blk_t [8][8];

  // Model: complete blocks wait in a queue; the head block is read column by column.
  blk_t fq[$];
  blk_t cur;
  int   wr_m = 0;
  int   rd_m = 0;

  int checks   = 0;
  int failures = 0;
  bit acc_row;
  bit acc_col;
  int nready_cnt;
  int xfer_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int r, input int c);
    return 32'((r << 4) | c);
  endfunction

  task automatic set_row(input int r, input int kind);
    for (int c = 0; c < 8; c++) begin
      if (kind == 0) iv[c] = pat(r, c);
      else if (kind == 1) iv[c] = 32'h3F80_0000;
      else iv[c] = $urandom();
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    bit e_ir, e_ov, e_ol;
    logic [31:0] e_c;
    @(negedge clk);
    e_ir = en && !reset && (fq.size() < CAP);
    e_ov = en && !reset && (fq.size() > 0);
    e_ol = e_ov && (rd_m == 7);
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
    chk("out_last", {31'd0, out_last}, {31'd0, e_ol});
    for (int k = 0; k < 8; k++) begin
      e_c = e_ov ? fq[0][k][rd_m] : 32'd0;
      chk($sformatf("C%0d", k), cv[k], e_c);
    end
    if (in_valid && !in_ready) nready_cnt++;
    if (out_valid && out_ready) xfer_cnt++;
    @(posedge clk);
    acc_row = e_ir && in_valid;
    acc_col = e_ov && out_ready;
    if (reset) begin
      fq.delete();
      wr_m = 0;
      rd_m = 0;
    end else begin
      if (acc_col) begin
        if (rd_m == 7) begin
          fq.delete(0);
          rd_m = 0;
        end else begin
          rd_m++;
        end
      end
      if (acc_row) begin
        for (int c = 0; c < 8; c++) cur[wr_m][c] = iv[c];
        if (wr_m == 7) begin
          fq.push_back(cur);
          wr_m = 0;
        end else begin
          wr_m++;
        end
      end
    end
    #1;
  endtask

  task automatic send_rows(input int first, input int n, input int kind, input int budget);
    int r = 0;
    int t = 0;
    set_row((first + r) % 8, kind);
    while (r < n && t < budget) begin
      in_valid = 1'b1;
      step();
      if (acc_row) begin
        r++;
        set_row((first + r) % 8, kind);
      end
      t++;
    end
    in_valid = 1'b0;
    chk("send_rows_done", r, n);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((fq.size() > 0 || out_valid) && t < budget) begin
      step();
      t++;
    end
    chk("drain_idle", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int hold;
    int t;
    reset = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) iv[c] = '0;
    nready_cnt = 0;
    xfer_cnt = 0;

    // Reset state, then first cycle after reset must be ready.
    step();
    step();
    reset = 1'b0;
    step();

    // Basic transpose with the {row,col} pattern.
    send_rows(0, 8, 0, 20);
    chk("basic_first_C5", cv[5], 32'h50);
    chk("basic_first_C2", cv[2], 32'h20);
    drain(20);

    // Backpressure: stall five cycles on column 3.
    send_rows(0, 8, 0, 20);
    hold = 0;
    t = 0;
    while ((fq.size() > 0 || out_valid) && t < 40) begin
      out_ready = !(rd_m == 3 && hold < 5);
      if (!out_ready) hold++;
      step();
      if (hold > 0 && hold <= 5 && rd_m == 3) begin
        chk("bp_C0", cv[0], 32'h03);
        chk("bp_C7", cv[7], 32'h73);
        chk("bp_last", {31'd0, out_last}, 32'd0);
      end
      t++;
    end
    out_ready = 1'b1;
    chk("bp_hold_cycles", hold, 5);
    drain(10);

    // Back-to-back blocks; the second block's last row meets the first block's last column.
    nready_cnt = 0;
    xfer_cnt = 0;
    send_rows(0, 16, 2, 60);
    drain(30);
    chk("stream_not_ready_cycles", nready_cnt, (CAP == 2) ? 0 : 8);
    chk("stream_columns", xfer_cnt, 16);

    // Enable freeze after row 4.
    send_rows(0, 5, 0, 20);
    en = 1'b0;
    in_valid = 1'b1;
    set_row(5, 0);
    repeat (4) step();
    en = 1'b1;
    send_rows(5, 3, 0, 20);
    chk("freeze_C3_col0", cv[3], 32'h30);
    drain(20);

    // Reset mid-block, then a block of 1.0f.
    send_rows(0, 3, 2, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_rows(0, 8, 1, 20);
    for (int j = 0; j < 8; j++) begin
      chk("one_C0", cv[0], 32'h3F80_0000);
      chk("one_C7", cv[7], 32'h3F80_0000);
      step();
    end
    drain(10);

    // Random handshakes and enable.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      set_row(0, 2);
      step();
    end
    en = 1'b1;
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
